sha2_sigma_cfu: RTL and testbench

Parametrised, pipelined CFU that computes all four SHA-2 message-schedule and compression sigma functions (σ0, σ1, Σ0, Σ1) for SHA-256 or SHA-512. It attaches to the core as a `cfu_interface` slave. Unlike the single-function, single-outstanding σ1 unit, it has three properties:
- the function is selected per request;
- latency is configurable;
- it keeps multiple requests in flight, with a credit-guarded response FIFO.

---
 rtl/sha2_sigma_cfu.sv | 172 +++++++++++++++++
 tb/tb_sha2_sigma_cfu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_sigma_cfu.sv
// sha2_sigma_cfu: SHA-256/SHA-512 sigma-function unit. Selects one of four sigma functions per
// request, delays the result through a fixed-latency pipeline and returns it in order from a
// response FIFO. A credit counter reserves one FIFO slot for every in-flight request.
module sha2_sigma_cfu #(
   parameter int unsigned DATA_WIDTH = 32,  // 32 = SHA-256, 64 = SHA-512
   parameter int unsigned LATENCY    = 1,   // 1..4
   parameter int unsigned FIFO_DEPTH = 4,   // power of two, >= LATENCY
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned FUNC_WIDTH = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [ID_WIDTH-1:0]   i_req_id,
   input  logic [FUNC_WIDTH-1:0] i_req_function_id,
   input  logic [DATA_WIDTH-1:0] i_req_data0,
   output logic                  o_resp_valid,
   input  logic                  i_resp_ready,
   output logic [ID_WIDTH-1:0]   o_resp_id,
   output logic                  o_resp_status,
   output logic [DATA_WIDTH-1:0] o_resp_data
);

   localparam bit          IS512 = (DATA_WIDTH == 64);
   localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   // Rotate / shift amounts for each function, chosen by word size
   localparam int unsigned S0_A = IS512 ? 1  : 7;
   localparam int unsigned S0_B = IS512 ? 8  : 18;
   localparam int unsigned S0_S = IS512 ? 7  : 3;
   localparam int unsigned S1_A = IS512 ? 19 : 17;
   localparam int unsigned S1_B = IS512 ? 61 : 19;
   localparam int unsigned S1_S = IS512 ? 6  : 10;
   localparam int unsigned B0_A = IS512 ? 28 : 2;
   localparam int unsigned B0_B = IS512 ? 34 : 13;
   localparam int unsigned B0_C = IS512 ? 39 : 22;
   localparam int unsigned B1_A = IS512 ? 14 : 6;
   localparam int unsigned B1_B = IS512 ? 18 : 11;
   localparam int unsigned B1_C = IS512 ? 41 : 25;

   function automatic logic [DATA_WIDTH-1:0] ror(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
      return (x >> n) | (x << (DATA_WIDTH - n));
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   logic                  w_accept;
   logic                  w_pop;
   logic                  w_illegal;
   logic [DATA_WIDTH-1:0] w_sigma;
   logic [DATA_WIDTH-1:0] w_res_data;

   logic                  w_wr_valid;
   logic [ID_WIDTH-1:0]   w_wr_id;
   logic                  w_wr_status;
   logic [DATA_WIDTH-1:0] w_wr_data;

   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         r_used;

   logic [ID_WIDTH-1:0]   r_mem_id   [FIFO_DEPTH];
   logic                  r_mem_sts  [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];

   assign o_req_ready = (r_used < DEPTH_C);
   assign w_accept    = i_req_valid & o_req_ready;
   assign o_resp_valid = (r_cnt != '0);
   assign w_pop       = o_resp_valid & i_resp_ready;

   // Sigma function of the request operand; illegal codes yield zero data
   always_comb begin
      w_illegal = |(i_req_function_id >> 2);
      w_sigma   = '0;
      unique case (i_req_function_id[1:0])
         2'd0: w_sigma = ror(i_req_data0, S0_A) ^ ror(i_req_data0, S0_B) ^ (i_req_data0 >> S0_S);
         2'd1: w_sigma = ror(i_req_data0, S1_A) ^ ror(i_req_data0, S1_B) ^ (i_req_data0 >> S1_S);
         2'd2: w_sigma = ror(i_req_data0, B0_A) ^ ror(i_req_data0, B0_B) ^ ror(i_req_data0, B0_C);
         2'd3: w_sigma = ror(i_req_data0, B1_A) ^ ror(i_req_data0, B1_B) ^ ror(i_req_data0, B1_C);
      endcase
      w_res_data = w_illegal ? '0 : w_sigma;
   end

   // The FIFO write is the last register stage, so LATENCY-1 stages sit in front of it
   generate
      if (LATENCY == 1) begin : g_direct
         assign w_wr_valid  = w_accept;
         assign w_wr_id     = i_req_id;
         assign w_wr_status = w_illegal;
         assign w_wr_data   = w_res_data;
      end else begin : g_pipe
         localparam int unsigned NS = LATENCY - 1;
         logic                  r_vld [NS];
         logic [ID_WIDTH-1:0]   r_id  [NS];
         logic                  r_sts [NS];
         logic [DATA_WIDTH-1:0] r_dat [NS];

         // Advance every stage each cycle; credits make stalling unnecessary
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < NS; i++) begin
                  r_vld[i] <= 1'b0;
                  r_id[i]  <= '0;
                  r_sts[i] <= 1'b0;
                  r_dat[i] <= '0;
               end
            end else begin
               r_vld[0] <= w_accept;
               r_id[0]  <= i_req_id;
               r_sts[0] <= w_illegal;
               r_dat[0] <= w_res_data;
               for (int i = 1; i < NS; i++) begin
                  r_vld[i] <= r_vld[i-1];
                  r_id[i]  <= r_id[i-1];
                  r_sts[i] <= r_sts[i-1];
                  r_dat[i] <= r_dat[i-1];
               end
            end
         end

         assign w_wr_valid  = r_vld[NS-1];
         assign w_wr_id     = r_id[NS-1];
         assign w_wr_status = r_sts[NS-1];
         assign w_wr_data   = r_dat[NS-1];
      end
   endgenerate

   // FIFO storage; a reserved slot always exists when the pipeline delivers
   always_ff @(posedge clk) begin
      if (w_wr_valid) begin
         r_mem_id[r_wptr]   <= w_wr_id;
         r_mem_sts[r_wptr]  <= w_wr_status;
         r_mem_data[r_wptr] <= w_wr_data;
      end
   end

   // Pointers, FIFO occupancy and the credit counter (in-flight + buffered)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
         r_used <= '0;
      end else begin
         if (w_wr_valid) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)      r_rptr <= ptr_inc(r_rptr);
         case ({w_wr_valid, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: ;
         endcase
         case ({w_accept, w_pop})
            2'b10:   r_used <= r_used + CW'(1);
            2'b01:   r_used <= r_used - CW'(1);
            default: ;
         endcase
      end
   end

   // Head of FIFO, forced to zero while empty so reset leaves the outputs at zero
   assign o_resp_id     = o_resp_valid ? r_mem_id[r_rptr]   : '0;
   assign o_resp_status = o_resp_valid ? r_mem_sts[r_rptr]  : 1'b0;
   assign o_resp_data   = o_resp_valid ? r_mem_data[r_rptr] : '0;

endmodule

// File: tb/tb_sha2_sigma_cfu.sv
// tb_sha2_sigma_cfu: scoreboard bench exercising four configurations of sha2_sigma_cfu.
// Instance 0: 32b L1 D4, 1: 32b L2 D4, 2: 32b L4 D8, 3: 64b L2 D4.
module tb_sha2_sigma_cfu;

   typedef struct {
      logic [7:0]  id;
      logic [6:0]  fn;
      logic [63:0] data;
      logic        has_exp;
      logic [63:0] exp;
   } stim_t;

   typedef struct {
      logic [7:0]  id;
      logic        st;
      logic [63:0] dat;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  vld_vec;
   logic [7:0]  r_id;
   logic [6:0]  r_fn;
   logic [63:0] r_data;
   logic        r_rdy;

   logic [3:0]  rdy_o;
   logic [3:0]  rvld;
   logic [3:0]  rsts;
   logic [7:0]  rid [4];
   logic [31:0] d_a, d_b, d_c;
   logic [63:0] d_d;
   logic [63:0] rdat [4];

   stim_t stq[$];
   exp_t  sb[$];
   int    sel;
   int    cyc;
   bit    chk_lat;
   int    lat_exp;
   int    stalls;
   int    n_checks;
   int    n_errs;
   logic  last_rdy;
   logic  last_vld;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      rdat[0] = {32'h0, d_a};
      rdat[1] = {32'h0, d_b};
      rdat[2] = {32'h0, d_c};
      rdat[3] = d_d;
   end

   sha2_sigma_cfu #(.DATA_WIDTH(32), .LATENCY(1), .FIFO_DEPTH(4)) u_a (
      .clk(clk), .rst(rst), .i_req_valid(vld_vec[0]), .o_req_ready(rdy_o[0]),
      .i_req_id(r_id), .i_req_function_id(r_fn), .i_req_data0(r_data[31:0]),
      .o_resp_valid(rvld[0]), .i_resp_ready(r_rdy), .o_resp_id(rid[0]),
      .o_resp_status(rsts[0]), .o_resp_data(d_a));

   sha2_sigma_cfu #(.DATA_WIDTH(32), .LATENCY(2), .FIFO_DEPTH(4)) u_b (
      .clk(clk), .rst(rst), .i_req_valid(vld_vec[1]), .o_req_ready(rdy_o[1]),
      .i_req_id(r_id), .i_req_function_id(r_fn), .i_req_data0(r_data[31:0]),
      .o_resp_valid(rvld[1]), .i_resp_ready(r_rdy), .o_resp_id(rid[1]),
      .o_resp_status(rsts[1]), .o_resp_data(d_b));

   sha2_sigma_cfu #(.DATA_WIDTH(32), .LATENCY(4), .FIFO_DEPTH(8)) u_c (
      .clk(clk), .rst(rst), .i_req_valid(vld_vec[2]), .o_req_ready(rdy_o[2]),
      .i_req_id(r_id), .i_req_function_id(r_fn), .i_req_data0(r_data[31:0]),
      .o_resp_valid(rvld[2]), .i_resp_ready(r_rdy), .o_resp_id(rid[2]),
      .o_resp_status(rsts[2]), .o_resp_data(d_c));

   sha2_sigma_cfu #(.DATA_WIDTH(64), .LATENCY(2), .FIFO_DEPTH(4)) u_d (
      .clk(clk), .rst(rst), .i_req_valid(vld_vec[3]), .o_req_ready(rdy_o[3]),
      .i_req_id(r_id), .i_req_function_id(r_fn), .i_req_data0(r_data),
      .o_resp_valid(rvld[3]), .i_resp_ready(r_rdy), .o_resp_id(rid[3]),
      .o_resp_status(rsts[3]), .o_resp_data(d_d));

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] msk(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      return ((x >> n) | (x << (w - n))) & msk(w);
   endfunction

   // Reference sigma functions, written out from the SHA-2 definitions
   function automatic logic [63:0] model(input int w, input int fn, input logic [63:0] x);
      if (fn > 3) return 64'h0;
      if (w == 32) begin
         case (fn)
            0:       return rotr(x, 7, w)  ^ rotr(x, 18, w) ^ (x >> 3);
            1:       return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
            2:       return rotr(x, 2, w)  ^ rotr(x, 13, w) ^ rotr(x, 22, w);
            default: return rotr(x, 6, w)  ^ rotr(x, 11, w) ^ rotr(x, 25, w);
         endcase
      end
      case (fn)
         0:       return rotr(x, 1, w)  ^ rotr(x, 8, w)  ^ (x >> 7);
         1:       return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
         2:       return rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w);
         default: return rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w);
      endcase
   endfunction

   task automatic add(input logic [7:0] id, input logic [6:0] fn, input logic [63:0] data,
                      input logic has_exp, input logic [63:0] exp);
      stim_t s;
      s.id      = id;
      s.fn      = fn;
      s.data    = data & msk((sel == 3) ? 64 : 32);
      s.has_exp = has_exp;
      s.exp     = exp;
      stq.push_back(s);
   endtask

   task automatic add_rand(input logic [7:0] id);
      add(id, 7'($urandom_range(3, 0)), {$urandom, $urandom}, 1'b0, 64'h0);
   endtask

   // One clock cycle: offer the stimulus head, then at the falling edge score the response
   // handshake and record the request handshake that the next rising edge completes.
   task automatic tick();
      exp_t  e;
      stim_t s;
      vld_vec = '0;
      if (stq.size() > 0) begin
         r_id       = stq[0].id;
         r_fn       = stq[0].fn;
         r_data     = stq[0].data;
         vld_vec[sel] = 1'b1;
      end
      @(negedge clk);
      last_rdy = rdy_o[sel];
      last_vld = rvld[sel];
      if (rvld[sel] && r_rdy) begin
         check("resp_expected", 64'(sb.size() != 0), 64'h1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("resp_id", 64'(rid[sel]), 64'(e.id));
            check("resp_status", 64'(rsts[sel]), 64'(e.st));
            check("resp_data", rdat[sel], e.dat);
            if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(lat_exp));
         end
      end
      if (vld_vec[sel]) begin
         if (rdy_o[sel]) begin
            s     = stq.pop_front();
            e.id  = s.id;
            e.st  = (s.fn > 7'd3);
            e.dat = s.has_exp ? s.exp : model((sel == 3) ? 64 : 32, int'(s.fn), s.data);
            e.cyc = cyc;
            sb.push_back(e);
         end else begin
            stalls++;
         end
      end
      @(posedge clk);
      #1;
      vld_vec = '0;
   endtask

   task automatic pump(input int budget);
      int n;
      n = 0;
      while ((stq.size() != 0 || sb.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_left", 64'(stq.size() + sb.size()), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errs   = 0;
      cyc      = 0;
      stalls   = 0;
      chk_lat  = 1'b0;
      lat_exp  = 1;
      sel      = 0;
      vld_vec  = '0;
      r_id     = '0;
      r_fn     = '0;
      r_data   = '0;
      r_rdy    = 1'b1;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(rdy_o), 64'hF);
      check("rst_valid", 64'(rvld), 64'h0);
      check("rst_status", 64'(rsts), 64'h0);
      check("rst_id", 64'(rid[0]), 64'h0);
      check("rst_data", rdat[3], 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // SHA-256 vectors at latency 1, with an illegal code between legal neighbours
      sel = 0; chk_lat = 1'b1; lat_exp = 1; stalls = 0;
      add(8'd0, 7'd0, 64'h8000_0000, 1'b1, 64'h1100_2000);
      add(8'd1, 7'd1, 64'h8000_0000, 1'b1, 64'h0020_5000);
      add(8'd2, 7'd2, 64'h0000_0001, 1'b1, 64'h4008_0400);
      add(8'd3, 7'd4, 64'hFFFF_FFFF, 1'b1, 64'h0);
      add(8'd4, 7'd3, 64'h0000_0001, 1'b1, 64'h0420_0080);
      for (int i = 5; i < 15; i++) add_rand(8'(i));
      pump(60);
      check("a_stalls", 64'(stalls), 64'h0);

      // Back-pressure at latency 2, depth 4
      sel = 1; chk_lat = 1'b0; r_rdy = 1'b0;
      for (int i = 0; i < 8; i++) add_rand(8'(i));
      for (int c = 0; c < 8; c++) begin
         tick();
         check("bp_ready", 64'(last_rdy), 64'(c < 4));
         check("bp_valid", 64'(last_vld), 64'(c >= 2));
      end
      check("bp_accepted", 64'(8 - stq.size()), 64'h4);
      r_rdy = 1'b1;
      pump(60);

      // Streaming at latency 4, depth 8: full throughput, fixed latency
      sel = 2; chk_lat = 1'b1; lat_exp = 4; stalls = 0;
      for (int i = 0; i < 100; i++) add_rand(8'(i));
      pump(300);
      check("stream_stalls", 64'(stalls), 64'h0);

      // Reset with three requests in flight and two buffered
      chk_lat = 1'b0; r_rdy = 1'b0;
      for (int i = 0; i < 5; i++) add_rand(8'(i + 16));
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", 64'(rdy_o[2]), 64'h1);
      check("arst_valid", 64'(rvld[2]), 64'h0);
      check("arst_id", 64'(rid[2]), 64'h0);
      check("arst_data", rdat[2], 64'h0);
      sb.delete();
      stq.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      r_rdy = 1'b1;
      repeat (10) tick();
      chk_lat = 1'b1;
      add(8'h55, 7'd1, 64'h8000_0000, 1'b1, 64'h0020_5000);
      pump(20);

      // SHA-512 at latency 2
      sel = 3; lat_exp = 2;
      add(8'd10, 7'd1, 64'h0000_0000_0000_0001, 1'b1, 64'h0000_2000_0000_0008);
      add(8'd11, 7'd2, 64'h0000_0000_0000_0001, 1'b1, 64'h0000_0010_4200_0000);
      for (int i = 12; i < 20; i++) add_rand(8'(i));
      add(8'd20, 7'd64, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0);
      pump(60);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
